// File: rtl/jpeg_pkg.sv
// Shared JPEG definitions: stuffer FSM states and marker constants.
// Used by the byte stuffer and its bench.
package jpeg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    HI_STUFF,
    LO,
    LO_STUFF,
    EOI_FF,
    EOI_D9
  } state_t;

  localparam logic [7:0] MARKER_FF  = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic [7:0] EOI_CODE   = 8'hD9;

  function automatic logic [7:0] byte_of(
    input state_t      s,
    input logic [15:0] w
  );
    logic [7:0] b;
    b = STUFF_BYTE;
    case (s)
      HI:      b = w[15:8];
      LO:      b = w[7:0];
      EOI_FF:  b = MARKER_FF;
      EOI_D9:  b = EOI_CODE;
      default: b = STUFF_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_stuffer.sv
// JPEG byte stuffer: splits 16-bit code words into bytes, inserts 00
// after every FF data byte and optionally appends the FF D9 EOI marker.
module byte_stuffer
  import jpeg_pkg::*;
#(
  parameter int EOI_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena_in,
  input  logic [15:0] in,
  input  logic        last,
  input  logic        last_bytes,
  output logic        rdy_out,
  output logic        ena_out,
  output logic [7:0]  out,
  input  logic        rdy_in
);

  state_t      state;
  state_t      nxt;
  state_t      done_nxt;
  logic [15:0] word;
  logic [15:0] nword;
  logic        w_last;
  logic        w_lb;
  logic        short_w;
  logic        eoi_pend;
  logic        fin;
  logic        take;
  logic        adv;

  assign short_w  = w_last && !w_lb;
  assign eoi_pend = (EOI_EN != 0) && w_last;
  assign adv      = ena_out && rdy_in;
  assign take     = ena_in && rdy_out;
  assign nword    = take ? in : word;

  // Flag the byte on out as the last data byte of the buffered word.
  always_comb begin
    fin = 1'b0;
    case (state)
      HI:       fin = (word[15:8] != MARKER_FF) && short_w;
      HI_STUFF: fin = short_w;
      LO:       fin = (word[7:0] != MARKER_FF);
      LO_STUFF: fin = 1'b1;
      default:  fin = 1'b0;
    endcase
  end

  // Accept a word when empty, or overlap with the final byte leaving.
  always_comb begin
    rdy_out = 1'b0;
    if (!rst) begin
      rdy_out = (state == IDLE) ||
                (fin && rdy_in && !eoi_pend);
    end
  end

  // Next state; EOI wins over a new word once a last word finishes.
  always_comb begin
    if (eoi_pend)  done_nxt = EOI_FF;
    else if (take) done_nxt = HI;
    else           done_nxt = IDLE;

    nxt = state;
    case (state)
      IDLE: begin
        if (take) nxt = HI;
      end
      HI: begin
        if (adv) begin
          if (word[15:8] == MARKER_FF) nxt = HI_STUFF;
          else if (short_w)            nxt = done_nxt;
          else                         nxt = LO;
        end
      end
      HI_STUFF: begin
        if (adv) nxt = short_w ? done_nxt : LO;
      end
      LO: begin
        if (adv) begin
          if (word[7:0] == MARKER_FF) nxt = LO_STUFF;
          else                        nxt = done_nxt;
        end
      end
      LO_STUFF: begin
        if (adv) nxt = done_nxt;
      end
      EOI_FF: begin
        if (adv) nxt = EOI_D9;
      end
      EOI_D9: begin
        if (adv) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Register state, word buffer and the byte presented downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      w_last  <= 1'b0;
      w_lb    <= 1'b0;
      ena_out <= 1'b0;
      out     <= STUFF_BYTE;
    end else begin
      state   <= nxt;
      ena_out <= (nxt != IDLE);
      out     <= byte_of(nxt, nword);
      if (take) begin
        word   <= in;
        w_last <= last;
        w_lb   <= last_bytes;
      end
    end
  end

endmodule

// File: tb/tb_byte_stuffer.sv
// Bench for byte_stuffer: directed cases plus random traffic checked
// against a byte-list model built from the stuffing rules.
module tb_byte_stuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena_in;
  logic [15:0] in;
  logic        last;
  logic        last_bytes;
  logic        rdy_out;
  logic        ena_out;
  logic [7:0]  out;
  logic        rdy_in;

  byte_stuffer #(.EOI_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .ena_in(ena_in),
    .in(in),
    .last(last),
    .last_bytes(last_bytes),
    .rdy_out(rdy_out),
    .ena_out(ena_out),
    .out(out),
    .rdy_in(rdy_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic        l;
    logic        lb;
  } stim_t;

  stim_t      sq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         gotcyc[$];
  int         total = 0;
  int         passed = 0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] w, input logic l,
                     input logic lb);
    stim_t s;
    s.w = w;
    s.l = l;
    s.lb = lb;
    sq.push_back(s);
  endtask

  task automatic push_data(input logic [7:0] b);
    exp_q.push_back(b);
    if (b == 8'hFF) exp_q.push_back(8'h00);
  endtask

  task automatic build_exp();
    exp_q.delete();
    foreach (sq[i]) begin
      push_data(sq[i].w[15:8]);
      if (!(sq[i].l && !sq[i].lb)) push_data(sq[i].w[7:0]);
      if (sq[i].l) begin
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
      end
    end
  endtask

  task automatic run(input int rdy_pct, input int gap_pct,
                     input int budget);
    int cyc;
    int idx;
    cyc = 0;
    idx = 0;
    got.delete();
    gotcyc.delete();
    while ((idx < sq.size() || ena_out) && cyc < budget) begin
      ena_in = (idx < sq.size()) &&
               ($urandom_range(99) >= gap_pct);
      if (ena_in) begin
        in = sq[idx].w;
        last = sq[idx].l;
        last_bytes = sq[idx].lb;
      end else begin
        in = 16'($urandom);
        last = 1'($urandom);
        last_bytes = 1'($urandom);
      end
      rdy_in = ($urandom_range(99) < rdy_pct);
      #1;
      if (ena_out && rdy_in) begin
        got.push_back(out);
        gotcyc.push_back(cyc);
      end
      if (ena_in && rdy_out) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    ena_in = 1'b0;
    last = 1'b0;
    chk("run_done", 16'(cyc < budget), 16'd1);
  endtask

  task automatic compare(input string tag);
    int n;
    build_exp();
    chk({tag, "_len"}, 16'(got.size()), 16'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 16'(got[i]), 16'(exp_q[i]));
    sq.delete();
  endtask

  function automatic logic [7:0] rbyte();
    case ($urandom_range(3))
      0:       return 8'hFF;
      1:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int cnt;
    rst = 1'b1;
    ena_in = 1'b0;
    in = '0;
    last = 1'b0;
    last_bytes = 1'b0;
    rdy_in = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_rdy_out", 16'(rdy_out), 16'd0);
    chk("rst_ena_out", 16'(ena_out), 16'd0);
    chk("rst_out", 16'(out), 16'h00);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 16'(rdy_out), 16'd1);
    tick();

    add(16'h1234, 1'b0, 1'b0);
    run(100, 0, 50);
    chk("lat_first", 16'(gotcyc.size() > 0 ? gotcyc[0] : -1), 16'd1);
    chk("lat_second", 16'(gotcyc.size() > 1 ? gotcyc[1] : -1), 16'd2);
    compare("w1234");

    add(16'hFF00, 1'b0, 1'b0);
    run(100, 0, 50);
    compare("wFF00");
    add(16'h00FF, 1'b0, 1'b0);
    run(100, 0, 50);
    compare("w00FF");

    add(16'hABFF, 1'b1, 1'b1);
    run(100, 0, 50);
    #1;
    chk("eoi_rdy_after", 16'(rdy_out), 16'd1);
    compare("wABFF_eoi");

    add(16'hFF37, 1'b1, 1'b0);
    run(100, 0, 50);
    compare("wFF37_short");

    add(16'h1122, 1'b0, 1'b0);
    add(16'h3344, 1'b0, 1'b0);
    run(100, 0, 50);
    chk("b2b_span", 16'(gotcyc.size() > 3 ? gotcyc[3] - gotcyc[0] : -1),
        16'd3);
    compare("b2b");

    ena_in = 1'b1;
    in = 16'h1122;
    rdy_in = 1'b1;
    #1;
    chk("stall_acc1", 16'(rdy_out), 16'd1);
    tick();
    in = 16'h3344;
    #1;
    chk("stall_b11", 16'(out), 16'h11);
    chk("stall_busy", 16'(rdy_out), 16'd0);
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hold", 16'(out), 16'h22);
      chk("stall_ena", 16'(ena_out), 16'd1);
      chk("stall_rdy", 16'(rdy_out), 16'd0);
      tick();
    end
    rdy_in = 1'b1;
    #1;
    chk("stall_release", 16'(rdy_out), 16'd1);
    tick();
    ena_in = 1'b0;
    chk("stall_b33", 16'(out), 16'h33);
    tick();
    chk("stall_b44", 16'(out), 16'h44);
    tick();
    chk("stall_idle", 16'(ena_out), 16'd0);

    ena_in = 1'b1;
    in = 16'hFF00;
    rdy_in = 1'b1;
    #1;
    tick();
    ena_in = 1'b0;
    chk("mrst_ff", 16'(out), 16'hFF);
    rst = 1'b1;
    tick();
    chk("mrst_ena", 16'(ena_out), 16'd0);
    chk("mrst_out", 16'(out), 16'h00);
    chk("mrst_rdy", 16'(rdy_out), 16'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ena_out) cnt++;
      tick();
    end
    chk("mrst_no_tail", 16'(cnt), 16'd0);
    chk("mrst_rdy_after", 16'(rdy_out), 16'd1);

    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 40; i++) begin
        logic l;
        l = ($urandom_range(4) == 0);
        add({rbyte(), rbyte()}, l, 1'($urandom));
      end
      run((b == 0) ? 100 : 60, (b == 2) ? 40 : 10, 5000);
      compare($sformatf("rand%0d", b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
